// File: rtl/tdm_demux_8ch.sv
// 1-to-8 TDM demultiplexer: hunts for a slot-0 sync marker, then deserialises
// eight valid beats per frame into dout and flags framing violations.
module tdm_demux_8ch #(
    parameter bit SYNC_EVERY_FRAME = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sync,
    output logic [7:0] dout,
    output logic       frame_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [6:0] shadow_q, shadow_d;
    logic [7:0] dout_q, dout_d;
    logic       frame_valid_q, frame_valid_d;
    logic       sync_err_q, sync_err_d;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 3'd0;
            shadow_q      <= 7'h00;
            dout_q        <= 8'h00;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Next-state logic: non-beat cycles hold everything and clear the pulses.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d = {6'b000000, din};
                        slot_d   = 3'd1;
                        state_d  = LOCKED;
                    end else begin
                        slot_d   = 3'd0;
                    end
                end
                LOCKED: begin
                    // Re-align takes priority so it can never complete a frame.
                    if (sync && (slot_q != 3'd0)) begin
                        sync_err_d = 1'b1;
                        shadow_d   = {6'b000000, din};
                        slot_d     = 3'd1;
                    end else if (!sync && (slot_q == 3'd0) && SYNC_EVERY_FRAME) begin
                        sync_err_d = 1'b1;
                        slot_d     = 3'd0;
                        state_d    = HUNT;
                    end else begin
                        case (slot_q)
                            3'd0: shadow_d[0] = din;
                            3'd1: shadow_d[1] = din;
                            3'd2: shadow_d[2] = din;
                            3'd3: shadow_d[3] = din;
                            3'd4: shadow_d[4] = din;
                            3'd5: shadow_d[5] = din;
                            3'd6: shadow_d[6] = din;
                            default: begin
                                dout_d        = {din, shadow_q};
                                frame_valid_d = 1'b1;
                            end
                        endcase
                        slot_d = slot_q + 3'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule
